serial_subtractor16: RTL
========================

Name: serial_subtractor16

Overview:
- Multi-cycle 16-bit subtractor; the inverse operation of the team's combinational 16-bit adder with flags.
- Computes diff = a - b as a + ~b + 1, one 4-bit digit per clock, LSB digit first, with a ripple borrow chain held in a flop.
- Produces the same flag set as the adder: carry/borrow, zero, sign, parity, overflow.
- Sits in the datapath ALU, next to the adder, behind a start/ready/done handshake.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of DIGIT_W.
- DIGIT_W, 4, bits processed per clock.
- Derived (not overridable): NDIG = WIDTH/DIGIT_W = 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-low
- start  input  1  request; accepted only when ready=1
- a  input  WIDTH  minuend, captured on the accept edge
- b  input  WIDTH  subtrahend, captured on the accept edge
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse; results valid from this cycle onward
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  1 when a < b unsigned (inverted final carry)
- zero  output  1  diff == 0
- sign  output  1  diff[WIDTH-1]
- parity  output  1  ~^diff; 1 when diff has an even number of ones
- overflow  output  1  signed overflow: (a[15] & ~b[15] & ~diff[15]) | (~a[15] & b[15] & diff[15])

Behaviour:
- Reset: on a clk edge with rst_n=0, state goes to IDLE; digit counter, carry, operand regs, diff and all flags clear to 0; done=0; ready=1.
- Reset is honoured in every state. Reset in RUN aborts the operation: no done pulse, outputs cleared.
- FSM states:
  - IDLE: ready=1. If start=1, latch a and ~b, set carry=1 and count=0, go to RUN. If start=0, stay in IDLE.
  - RUN: ready=0. Each edge adds digit[count] of a, ~b and carry; writes that digit of the internal result; updates carry; increments count. After digit NDIG-1, registers diff and all flags, then goes to DONE.
  - DONE: done=1 for exactly this one cycle. Next edge goes to IDLE.
- Latency:
  - Accept edge E0. Digits are computed on E1..E4; done is high in the cycle after E4.
  - Throughput is one operation per 6 cycles.
- start while ready=0 (RUN or DONE) is ignored. Operand changes after E0 have no effect.
- Outputs: diff and flags hold their values from the last done until the next done or reset. They never show partial results.
- Flags are computed from the final diff and the latched operands. borrow = ~carry_out.

Optional Feature:
- Macro: SUB_SAT_EN.
- Defined: on signed overflow, diff saturates. If latched a[15]=0 (result too positive), diff = 0x7FFF; otherwise diff = 0x8000.
  - zero, sign and parity are computed from the saturated diff.
  - overflow and borrow still report the raw, unsaturated operation.
- Undefined: diff wraps modulo 2^16. No saturation logic is present.

Test Plan:
- a=0x0000, b=0x0000 -> diff=0x0000, borrow=0, zero=1, sign=0, parity=1, overflow=0. done high exactly in the cycle after the 4th edge following accept; ready low for 5 cycles.
- a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, zero=0, sign=1, parity=1, overflow=0.
- a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, sign=0, parity=0, overflow=1. With SUB_SAT_EN: diff=0x8000, sign=1, parity=0, overflow=1.
- a=0xFF2A, b=0xAAAA -> diff=0x5480, borrow=0, zero=0, sign=0, parity=1, overflow=0. Then a=b=0x1234 -> diff=0x0000, zero=1.
- start held high with a=0x0005, b=0x0003, and operands changed to 0xFFFF/0x0001 during RUN -> first result diff=0x0002. A second operation is accepted only on the IDLE cycle after done and returns 0xFFFE.
- rst_n=0 for one edge on the 2nd RUN cycle -> next cycle diff=0, all flags 0, ready=1, no done pulse. A subsequent 0x0010-0x0001 completes with diff=0x000F.

Source files
------------

// File: rtl/serial_subtractor16.sv
// Digit-serial subtractor: diff = a + ~b + 1, DIGIT_W bits per clock, LSB digit first, with adder-style flags.
// Optional build macro SUB_SAT_EN: saturate diff on signed overflow.
module serial_subtractor16 #(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             sign,
  output logic             parity,
  output logic             overflow
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);
`ifdef SUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ~^v;
  endfunction

  state_t             state_r, state_nx_s;
  logic [CNT_W-1:0]   count_r;
  logic               carry_r;
  logic [WIDTH-1:0]   a_r, nb_r, res_r;
  logic [WIDTH-1:0]   diff_r;
  logic               borrow_r, zero_r, sign_r, parity_r, overflow_r;
  logic               ready_r, done_r;
  logic [DIGIT_W:0]   digit_sum_s;
  logic [WIDTH-1:0]   res_nx_s, out_s;
  logic               ovf_s;

  // Next-state logic for the IDLE/RUN/DONE handshake
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx_s = ST_RUN;
        else       state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (count_r == LAST_DIG) state_nx_s = ST_DONE;
        else                     state_nx_s = ST_RUN;
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // One digit of a + ~b + carry, the assembled result and its flags
  always_comb begin
    digit_sum_s = {1'b0, a_r[int'(count_r)*DIGIT_W +: DIGIT_W]}
                + {1'b0, nb_r[int'(count_r)*DIGIT_W +: DIGIT_W]}
                + {{DIGIT_W{1'b0}}, carry_r};
    res_nx_s = res_r;
    res_nx_s[int'(count_r)*DIGIT_W +: DIGIT_W] = digit_sum_s[DIGIT_W-1:0];
    // nb_r holds ~b, so matching operand signs here means a and b had opposite signs
    ovf_s = (a_r[WIDTH-1] & nb_r[WIDTH-1] & ~res_nx_s[WIDTH-1])
          | (~a_r[WIDTH-1] & ~nb_r[WIDTH-1] & res_nx_s[WIDTH-1]);
`ifdef SUB_SAT_EN
    if (ovf_s) begin
      if (a_r[WIDTH-1]) out_s = SAT_NEG;
      else              out_s = SAT_POS;
    end else begin
      out_s = res_nx_s;
    end
`else
    out_s = res_nx_s;
`endif
  end

  // State, operand, digit-chain and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      count_r    <= '0;
      carry_r    <= 1'b0;
      a_r        <= '0;
      nb_r       <= '0;
      res_r      <= '0;
      diff_r     <= '0;
      borrow_r   <= 1'b0;
      zero_r     <= 1'b0;
      sign_r     <= 1'b0;
      parity_r   <= 1'b0;
      overflow_r <= 1'b0;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      ready_r <= (state_nx_s == ST_IDLE);
      done_r  <= (state_nx_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r     <= a;
            nb_r    <= ~b;
            carry_r <= 1'b1;
            count_r <= '0;
            res_r   <= '0;
          end
        end
        ST_RUN: begin
          res_r   <= res_nx_s;
          carry_r <= digit_sum_s[DIGIT_W];
          count_r <= count_r + CNT_W'(1);
          if (count_r == LAST_DIG) begin
            diff_r     <= out_s;
            borrow_r   <= ~digit_sum_s[DIGIT_W];
            zero_r     <= (out_s == '0);
            sign_r     <= out_s[WIDTH-1];
            parity_r   <= even_parity(out_s);
            overflow_r <= ovf_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready    = ready_r;
  assign done     = done_r;
  assign diff     = diff_r;
  assign borrow   = borrow_r;
  assign zero     = zero_r;
  assign sign     = sign_r;
  assign parity   = parity_r;
  assign overflow = overflow_r;

endmodule
